// File: rtl/fec_pkg.sv
// Shared Hamming(128,120) FEC constants and parity-check column generator.
// Used by the inner FEC encoder and the matching decoder.
package fec_pkg;

    localparam int HAM_K = 120;
    localparam int HAM_N = 128;
    localparam int HAM_P = 8;

    // i-th value in 1..127 (ascending) that is not a power of two; positions 1,2,4,..64 hold parity
    function automatic logic [6:0] ham_col(input int i);
        logic [6:0] col;
        int         n;
        col = '0;
        n   = 0;
        for (int v = 3; v < 128; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == i) col = v[6:0];
                n++;
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/hamming_inner_fec_encoder_if.sv
// Serial bit-stream bundle of the inner FEC encoder: message bits in, codeword bits out.
// master drives the message side; slave is the encoder.
interface hamming_inner_fec_encoder_if;
    logic data_in;
    logic en;
    logic data_out;
    logic valid;
    logic cw_start;
    logic overflow;

    modport master (output data_in, output en,
                    input  data_out, input valid, input cw_start, input overflow);
    modport slave  (input  data_in, input en,
                    output data_out, output valid, output cw_start, output overflow);
endinterface

// File: rtl/cw_serializer.sv
// Ping-pong 2x128-bit codeword store; emits one registered bit per cycle from the full send buffer.
// Latency: commit at edge T gives bit 0 at T+1 when idle; back-to-back codewords have no bubble.
module cw_serializer
    import fec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [6:0]           wr_addr,
    input  logic                 wr_bit,
    input  logic                 commit,
    input  logic [HAM_P-1:0]     parity,
    output logic [1:0]           full,
    output logic                 data_out,
    output logic                 valid,
    output logic                 cw_start
);

    logic [1:0][HAM_N-1:0] mem_q, mem_d;
    logic [1:0]            full_q, full_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [6:0]            rd_cnt_q, rd_cnt_d;
    logic                  data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  cw_start_q, cw_start_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_sel][wr_addr] = wr_bit;
        if (commit) mem_d[wr_sel][HAM_K +: HAM_P] = parity;
    end

    // Release of the send buffer and commit of the fill buffer never target the same flag.
    always_comb begin
        full_d     = full_q;
        rd_sel_d   = rd_sel_q;
        rd_cnt_d   = rd_cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        cw_start_d = 1'b0;
        if (full_q[rd_sel_q]) begin
            valid_d    = 1'b1;
            data_out_d = mem_q[rd_sel_q][rd_cnt_q];
            cw_start_d = (rd_cnt_q == 7'd0);
            if (rd_cnt_q == 7'(HAM_N - 1)) begin
                rd_cnt_d         = 7'd0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 7'd1;
            end
        end
        if (commit) full_d[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q     <= 2'b00;
            rd_sel_q   <= 1'b0;
            rd_cnt_q   <= 7'd0;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            cw_start_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            rd_sel_q   <= rd_sel_d;
            rd_cnt_q   <= rd_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            cw_start_q <= cw_start_d;
        end
    end

    assign full     = full_q;
    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign cw_start = cw_start_q;

endmodule

// File: rtl/hamming_inner_fec_encoder.sv
// Bit-serial systematic Hamming(128,120) encoder: collects 120 message bits, appends 8 parity bits.
// Latency 1 cycle from last message bit to codeword bit 0; no backpressure, bits arriving with both buffers full are dropped and flag overflow.
module hamming_inner_fec_encoder
    import fec_pkg::*;
#(
    parameter int K = 120,
    parameter int N = 128
) (
    input  logic                        clk,
    input  logic                        rstn,
    hamming_inner_fec_encoder_if.slave  bus
);

    if (K != HAM_K || N != HAM_N) begin : g_param_check
        $error("hamming_inner_fec_encoder supports only K=120, N=128");
    end

    logic [6:0]       wr_cnt_q, wr_cnt_d;
    logic [6:0]       syn_q, syn_d;
    logic             par_q, par_d;
    logic             fill_sel_q, fill_sel_d;
    logic             overflow_q, overflow_d;

    logic [6:0]       syn_next;
    logic             par_next;
    logic             wr_en;
    logic             commit;
    logic [HAM_P-1:0] parity;
    logic [1:0]       fill_full;

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        syn_d      = syn_q;
        par_d      = par_q;
        fill_sel_d = fill_sel_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        parity     = '0;
        syn_next   = syn_q ^ (bus.data_in ? ham_col(int'(wr_cnt_q)) : 7'd0);
        par_next   = par_q ^ bus.data_in;
        if (bus.en) begin
            if (fill_full[fill_sel_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_cnt_q == 7'(HAM_K - 1)) begin
                    // p[7] makes the whole codeword even weight
                    commit     = 1'b1;
                    parity     = {par_next ^ (^syn_next), syn_next};
                    wr_cnt_d   = 7'd0;
                    syn_d      = 7'd0;
                    par_d      = 1'b0;
                    fill_sel_d = ~fill_sel_q;
                end else begin
                    wr_cnt_d = wr_cnt_q + 7'd1;
                    syn_d    = syn_next;
                    par_d    = par_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt_q   <= 7'd0;
            syn_q      <= 7'd0;
            par_q      <= 1'b0;
            fill_sel_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            syn_q      <= syn_d;
            par_q      <= par_d;
            fill_sel_q <= fill_sel_d;
            overflow_q <= overflow_d;
        end
    end

    cw_serializer u_cw_serializer (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_sel   (fill_sel_q),
        .wr_addr  (wr_cnt_q),
        .wr_bit   (bus.data_in),
        .commit   (commit),
        .parity   (parity),
        .full     (fill_full),
        .data_out (bus.data_out),
        .valid    (bus.valid),
        .cw_start (bus.cw_start)
    );

    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_hamming_inner_fec_encoder.sv
// Randomised and directed bench for the Hamming(128,120) inner encoder against a schedule-level reference model.
module tb_hamming_inner_fec_encoder;

    typedef struct {
        int           t;     // edge at which the 120th bit was accepted
        int           s;     // edge of codeword bit 0
        int           e;     // edge of codeword bit 127
        logic [127:0] bits;
    } cw_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    hamming_inner_fec_encoder_if bus();

    hamming_inner_fec_encoder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc - 1);
        end
    endtask

    // Reference model state
    cw_t          cws[$];
    logic         fill[$];
    int           ovf_edge = -1;
    int           rst_edge = 0;
    logic [6:0]   pos[120];
    logic [127:0] rx_q[$];
    logic [127:0] rx_cw;
    int           rx_idx  = 0;
    int           run     = 0;
    int           max_run = 0;

    // Message bit i sits at Hamming position pos[i]: the i-th non-power-of-two in 1..127
    function automatic void build_pos();
        int n;
        n = 0;
        for (int v = 1; v < 128; v++) begin
            if (v != 1 && v != 2 && v != 4 && v != 8 && v != 16 && v != 32 && v != 64) begin
                pos[n] = 7'(v);
                n++;
            end
        end
    endfunction

    function automatic logic [7:0] ref_parity(input logic [119:0] m);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 7; j++)
            for (int i = 0; i < 120; i++)
                p[j] = p[j] ^ (m[i] & pos[i][j]);
        p[7] = (^m) ^ (^p[6:0]);
        return p;
    endfunction

    function automatic int held_at(input int k);
        int n;
        n = 0;
        foreach (cws[i]) if (cws[i].t < k && cws[i].e >= k) n++;
        return n;
    endfunction

    function automatic void complete(input int k);
        cw_t          c;
        logic [119:0] m;
        for (int i = 0; i < 120; i++) m[i] = fill[i];
        c.t    = k;
        c.s    = k + 1;
        if (cws.size() > 0 && cws[$].e + 1 > c.s) c.s = cws[$].e + 1;
        c.e    = c.s + 127;
        c.bits = {ref_parity(m), m};
        cws.push_back(c);
        fill.delete();
    endfunction

    // Drive one cycle of input and advance the model for the edge that will sample it.
    task automatic step(input logic en_i, input logic d_i, input logic rstn_i);
        int k;
        @(negedge clk);
        #1;
        k           = cyc;
        bus.en      = en_i;
        bus.data_in = d_i;
        rstn        = rstn_i;
        if (!rstn_i) begin
            cws.delete();
            fill.delete();
            ovf_edge = -1;
            rst_edge = k;
        end else if (en_i) begin
            if (held_at(k) == 2) begin
                if (ovf_edge < 0) ovf_edge = k;
            end else begin
                fill.push_back(d_i);
                if (fill.size() == 120) complete(k);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_msg(input logic [119:0] m);
        for (int i = 0; i < 120; i++) step(1'b1, m[i], 1'b1);
    endtask

    task automatic expect_one_cw(input string tag, input logic [119:0] m, input logic [7:0] p);
        logic [127:0] c;
        check_eq({tag, "_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            c = rx_q.pop_front();
            check_eq({tag, "_msg_lo"}, c[31:0], m[31:0]);
            check_eq({tag, "_msg_hi"}, c[119:88], m[119:88]);
            check_eq({tag, "_parity"}, c[127:120], p);
        end
    endtask

    always @(negedge clk) begin
        int           e;
        int           s;
        logic         ev;
        logic [127:0] b;
        e = cyc - 1;
        if (e >= 0) begin
            ev = 1'b0;
            b  = '0;
            s  = 0;
            foreach (cws[i]) if (cws[i].s <= e && e <= cws[i].e) begin
                ev = 1'b1;
                b  = cws[i].bits;
                s  = cws[i].s;
            end
            check_eq("valid", bus.valid, ev);
            check_eq("overflow", bus.overflow, (ovf_edge >= 0 && ovf_edge <= e));
            if (ev) begin
                check_eq("data_out", bus.data_out, b[e - s]);
                check_eq("cw_start", bus.cw_start, e == s);
            end
            if (e == rst_edge) begin
                check_eq("rst_data_out", bus.data_out, 0);
                check_eq("rst_cw_start", bus.cw_start, 0);
                rx_idx = 0;
                run    = 0;
            end
            if (bus.valid === 1'b1) begin
                if (bus.cw_start === 1'b1) rx_idx = 0;
                if (rx_idx < 128) rx_cw[rx_idx] = bus.data_out;
                if (rx_idx == 127) rx_q.push_back(rx_cw);
                rx_idx++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [119:0] m;
        logic         bits[360];
        int           idx;
        int           g;

        build_pos();
        bus.en      = 1'b0;
        bus.data_in = 1'b0;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("reset_valid", bus.valid, 0);
        check_eq("reset_overflow", bus.overflow, 0);

        // All-zero message
        rx_q.delete();
        m = '0;
        send_msg(m);
        idle(140);
        expect_one_cw("zero", m, 8'h00);

        // Single one at message bit 0 (position 3)
        m = '0;
        m[0] = 1'b1;
        send_msg(m);
        idle(140);
        expect_one_cw("bit0", m, 8'h83);

        // Single one at message bit 119 (position 127)
        m = '0;
        m[119] = 1'b1;
        send_msg(m);
        idle(140);
        expect_one_cw("bit119", m, 8'h7F);

        // All-ones message
        m = '1;
        send_msg(m);
        idle(140);
        expect_one_cw("ones", m, 8'hFF);

        // Three random messages at 15/16 input duty
        rx_q.delete();
        max_run = 0;
        for (int i = 0; i < 360; i++) bits[i] = 1'($urandom_range(0, 1));
        idx = 0;
        g   = 0;
        while (idx < 360) begin
            if (g % 16 == 15) begin
                step(1'b0, 1'b0, 1'b1);
            end else begin
                step(1'b1, bits[idx], 1'b1);
                idx++;
            end
            g++;
        end
        idle(420);
        check_eq("duty_count", rx_q.size(), 3);
        check_eq("duty_continuous", max_run >= 384, 1);
        check_eq("duty_overflow", bus.overflow, 0);

        // Continuous input overruns both buffers
        rx_q.delete();
        for (int i = 0; i < 360; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        check_eq("overrun_overflow", bus.overflow, 1);
        idle(10);
        check_eq("overrun_midcw_valid", bus.valid, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("midrst_valid", bus.valid, 0);
        check_eq("midrst_data_out", bus.data_out, 0);
        check_eq("midrst_cw_start", bus.cw_start, 0);
        check_eq("midrst_overflow", bus.overflow, 0);

        rx_q.delete();
        for (int i = 0; i < 120; i++) m[i] = 1'($urandom_range(0, 1));
        send_msg(m);
        idle(140);
        expect_one_cw("post_rst", m, ref_parity(m));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
